uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the 8N1 serial link: LSB first, 8 data bits, no parity, 1 stop bit. Oversamples the serial line on the shared 16x baud tick `b_tick`, validates the start bit, recovers the 8 data bits and checks the stop bit. It presents each good byte with a one-clock `rx_done` strobe. It sits between the pad-side `rx` line and the RX FIFO write port, and is the receive-side counterpart of the UART transmitter on the same `b_tick`.

## Interface
No parameters. Frame format and 16x oversampling are fixed.
- `clk` input 1 — system clock, single clock domain.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `b_tick` input 1 — one-`clk` pulse at 16x the baud rate, from the shared baud generator.
- `rx` input 1 — asynchronous serial line; idles high.
- `rx_data` output 8 — last good byte received; holds until the next good frame.
- `rx_done` output 1 — one-`clk` pulse when `rx_data` updates.
- `rx_busy` output 1 — high whenever the state is not IDLE.
- `frame_err` output 1 — one-`clk` pulse when the stop bit samples low.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer; `rx_s` is its output.
- **State.** States are IDLE, START, DATA, STOP.
- **Counters.** 4-bit tick counter `cnt` and 3-bit bit counter `bcnt`.
- **Counter rule.** On each `b_tick` outside IDLE: if `cnt==15`, set `cnt=0` and advance the phase; otherwise `cnt` increments. Every action is keyed on the current `cnt` value at a `b_tick`. With no `b_tick`, nothing changes.
- **IDLE.** On a `b_tick` with `rx_s==0`: go to START, `cnt=0`. No edge qualification; detection is level-based.
- **START.**
  - `cnt==7`: capture the sample.
  - `cnt==8`: if the sample is 1 (false start/glitch), go to IDLE with no outputs.
  - `cnt==15`: go to DATA, `bcnt=0`.
- **DATA.**
  - `cnt==7`: capture the sample.
  - `cnt==8`: shift the sample into the shift register as `shift = {bit, shift[7:1]}` (LSB first).
  - `cnt==15`: if `bcnt==7`, go to STOP; otherwise `bcnt+1`.
- **STOP.**
  - `cnt==7`: capture the sample.
  - `cnt==8`, stop sample 1: `rx_data <= shift`, pulse `rx_done`, go to IDLE.
  - `cnt==8`, stop sample 0: pulse `frame_err`, leave `rx_data` unchanged, no `rx_done`, go to IDLE.
- **Break condition.** A line held low re-triggers START from IDLE and yields repeated `frame_err`.

## Timing
- **Reset values.** `rx_data=8'h00`, `rx_done=0`, `rx_busy=0`, `frame_err=0`; state IDLE; `cnt=0`, `bcnt=0`; synchronizer flops 1.
- **Reset mid-frame.** Asserting `rst_n` mid-frame returns to reset values immediately and drops the partial byte.
- **Synchronizer latency.** 2 `clk` from an `rx` transition to `rx_s`.
- **Tick schedule.** Let the detect tick be t0.
  - Start-bit sample at t8; false-start exit at t9.
  - Data bit i sampled at t(24+16i).
  - Stop bit sampled at t152.
  - Decision at t153.
- **Output timing.** `rx_done` and `frame_err` are registered: high for exactly the one `clk` after the t153 tick. `rx_data` is valid in that same cycle.
- **`rx_busy`.** Rises 1 `clk` after t0 and falls 1 `clk` after t153 (or after t9 on a false start).
- **Back-to-back frames.** Returning to IDLE at mid-stop-bit allows a start bit immediately after the stop bit. Back-to-back frames are received with no gap.
- **Simultaneous events.** `rx_done` and `frame_err` are never high together.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:**
  - The start, data and stop samples are each the 2-of-3 majority of `rx_s` taken at `cnt` 6, 7 and 8.
  - The decision moves to the same `cnt==8` tick; the majority includes that tick's sample.
- **Undefined:** single sample at `cnt==7`.
- Decision timing and all output timing are identical in both builds.

## Test plan
- **Single good byte.** Reset, then send 0xA5 with a clean 8N1 frame (`b_tick` every 8 `clk`) -> one `rx_done` pulse; `rx_data=0xA5`; `frame_err` stays 0; `rx_busy` low afterward.
- **Back-to-back bytes.** Send 0x00, 0xFF, 0x3C with no idle gap -> three `rx_done` pulses with `rx_data` 0x00, 0xFF, 0x3C in order, each valid in its pulse cycle.
- **False start.** Drive a 4-tick low glitch on `rx` -> return to IDLE by t9; no `rx_done`; no `frame_err`; `rx_data` unchanged.
- **Framing error.** Send 0x5A with the stop bit low -> `frame_err` pulses once; no `rx_done`; `rx_data` keeps the prior value. A following good 0x11 then yields `rx_done` with `rx_data=0x11`.
- **Reset mid-frame.** Assert `rst_n` low during data bit 3, then release, then send 0x81 -> all outputs at reset values during reset; 0x81 received correctly after release.
- **Majority vote (`UART_RX_MAJORITY_EN` defined).** Send 0xC3 with a 1-tick inverted glitch at `cnt==7` of every data bit -> `rx_data=0xC3`. The same stimulus without the macro corrupts the byte.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled on b_tick, LSB first.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority of rx_s at cnt 6/7/8.
module uart_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       b_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [2:0] r_bcnt;
    logic [2:0] w_bcnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_ferr;
    logic       w_ferr_nxt;
    logic       w_rx_s;
    logic       w_bit;

`ifdef UART_RX_MAJORITY_EN
    logic       r_s6;
    logic       r_s7;
    logic       w_s6_nxt;
    logic       w_s7_nxt;
`else
    logic       r_samp;
    logic       w_samp_nxt;
`endif

    assign w_rx_s    = r_sync2;
    assign rx_data   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != S_IDLE);

`ifdef UART_RX_MAJORITY_EN
    // Bit value used at the cnt==8 decision: majority including this tick.
    assign w_bit = (r_s6 & r_s7) | (r_s6 & w_rx_s) | (r_s7 & w_rx_s);
`else
    // Bit value used at the cnt==8 decision: the cnt==7 capture.
    assign w_bit = r_samp;
`endif

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters, sample/shift registers and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_bcnt  <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            r_s6    <= 1'b1;
            r_s7    <= 1'b1;
`else
            r_samp  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_MAJORITY_EN
            r_s6    <= w_s6_nxt;
            r_s7    <= w_s7_nxt;
`else
            r_samp  <= w_samp_nxt;
`endif
        end
    end

    // Next-state and datapath updates, all keyed on the current cnt at a b_tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        w_s6_nxt    = r_s6;
        w_s7_nxt    = r_s7;
`else
        w_samp_nxt  = r_samp;
`endif
        if (b_tick) begin
            if (r_state != S_IDLE) begin
                w_cnt_nxt = r_cnt + 4'd1;
`ifdef UART_RX_MAJORITY_EN
                if (r_cnt == 4'd6) w_s6_nxt = w_rx_s;
                if (r_cnt == 4'd7) w_s7_nxt = w_rx_s;
`else
                if (r_cnt == 4'd7) w_samp_nxt = w_rx_s;
`endif
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_START: begin
                    if (r_cnt == 4'd8 && w_bit) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else if (r_cnt == 4'd15) begin
                        w_state_nxt = S_DATA;
                        w_bcnt_nxt  = 3'd0;
                    end
                end
                S_DATA: begin
                    if (r_cnt == 4'd8) begin
                        w_shift_nxt = {w_bit, r_shift[7:1]};
                    end else if (r_cnt == 4'd15) begin
                        if (r_bcnt == 3'd7) w_state_nxt = S_STOP;
                        else w_bcnt_nxt = r_bcnt + 3'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == 4'd8) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                        if (w_bit) begin
                            w_data_nxt = r_shift;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of 8N1 reception, directed table + random frames.
// Expects 0xC3 or 0x3C on the glitch frame depending on UART_RX_MAJORITY_EN.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int divcnt = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        int         gap;
    } vec_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;
    vec_t       vt[6];

    uart_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .b_tick   (b_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        divcnt <= (divcnt == 7) ? 0 : divcnt + 1;
        b_tick <= (divcnt == 7);
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Wait n b_tick edges, then step just past the edge.
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!b_tick);
        end
        #1;
    endtask

    // Frame-level model: a good stop yields the byte, a low stop a framing error.
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.is_err = !stop_ok;
        if (stop_ok) last_good = b;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit glitch);
        rx = 1'b0;
        tk(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch) begin
                tk(8);
                rx = ~b[i];
                tk(1);
                rx = b[i];
                tk(7);
            end else begin
                tk(16);
            end
        end
        rx = stop_ok;
        tk(16);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (rx_done || frame_err)) begin
            chk("done_ferr_excl", 32'(rx_done & frame_err), 32'd0);
            chk("pulse_width", 32'(prev_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(rx_done), 32'(frame_err));
                chk("unexpected_event_any", 32'd1, 32'(exp_q.size()));
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind_ferr", 32'(frame_err), 32'(mon_e.is_err));
                chk("rx_data", 32'(rx_data), 32'(mon_e.data));
            end
        end
        prev_pulse <= rx_done | frame_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_g;
        logic [7:0] rb;
        bit         ok;
        int         gap;

        vt[0] = '{8'hA5, 1'b1, 4};
        vt[1] = '{8'h00, 1'b1, 0};
        vt[2] = '{8'hFF, 1'b1, 0};
        vt[3] = '{8'h3C, 1'b1, 2};
        vt[4] = '{8'h5A, 1'b0, 2};
        vt[5] = '{8'h11, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_rx_busy", 32'(rx_busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        tk(4);
        chk("post_rst_busy", 32'(rx_busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            expect_frame(vt[k].b, vt[k].stop_ok);
            send_frame(vt[k].b, vt[k].stop_ok, 1'b0);
            if (vt[k].stop_ok) chk("busy_after_frame", 32'(rx_busy), 32'd0);
            tk(16 * vt[k].gap);
        end
        tk(20);
        chk("table_all_events", 32'(exp_q.size()), 32'd0);
        chk("table_rx_data_hold", 32'(rx_data), 32'h11);

        rx = 1'b0;
        tk(4);
        chk("fs_busy_high", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        tk(6);
        chk("fs_idle_by_t9", 32'(rx_busy), 32'd0);
        tk(30);
        chk("fs_no_event", 32'(exp_q.size()), 32'd0);
        chk("fs_rx_data", 32'(rx_data), 32'h11);

        rb = 8'h81;
        rx = 1'b0;
        tk(16);
        for (int i = 0; i < 3; i++) begin
            rx = rb[i];
            tk(16);
        end
        rx = rb[3];
        tk(8);
        chk("mid_busy_before_rst", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_done", 32'(rx_done), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        rx = 1'b1;
        last_good = 8'h00;
        tk(3);
        rst_n = 1'b1;
        tk(3);
        expect_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0);
        tk(20);
        chk("after_rst_events", 32'(exp_q.size()), 32'd0);
        chk("after_rst_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_MAJORITY_EN
        exp_g = 8'hC3;
`else
        exp_g = 8'h3C;
`endif
        exp_q.push_back('{1'b0, exp_g});
        last_good = exp_g;
        send_frame(8'hC3, 1'b1, 1'b1);
        tk(20);
        chk("glitch_events", 32'(exp_q.size()), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'(exp_g));

        for (int k = 0; k < 25; k++) begin
            rb = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            expect_frame(rb, ok);
            send_frame(rb, ok, 1'b0);
            if (!ok) gap = 16 + $urandom_range(0, 20);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = $urandom_range(1, 40);
            tk(gap);
        end
        tk(40);
        chk("rand_all_events", 32'(exp_q.size()), 32'd0);
        chk("rand_rx_data_hold", 32'(rx_data), 32'(last_good));
        chk("end_busy", 32'(rx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
